// File: rtl/demux4_seq_pkg.sv
// Shared definitions for the demux4_seq registered 1-to-4 demultiplexer:
// lane indices, frame FSM state encodings and the one-hot lane decoder.
package demux4_seq_pkg;

  localparam logic [1:0] LANE_A = 2'd0;
  localparam logic [1:0] LANE_B = 2'd1;
  localparam logic [1:0] LANE_C = 2'd2;
  localparam logic [1:0] LANE_D = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/demux4_rr_ptr.sv
// 2-bit wrapping round-robin pointer with count enable and synchronous
// load-zero; load and enable together yield 1 (zero, then one step).
module demux4_rr_ptr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  output logic [1:0] ptr
);

  logic [1:0] base;

  assign base = load ? 2'd0 : ptr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else if (load || en) begin
      ptr <= base + {1'b0, en};
    end
  end

endmodule

// File: rtl/demux4_seq.sv
// Registered 1-to-4 demultiplexer with round-robin or explicit lane select
// and frame-completion tracking. Define DEMUX4_OVERWRITE_ERR_EN to add overwrite_err.
module demux4_seq
  import demux4_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       sel,
  input  logic             auto_mode,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [3:0]       out_valid,
  output logic [3:0]       filled,
  output logic             frame_done,
  output logic [1:0]       ptr
`ifdef DEMUX4_OVERWRITE_ERR_EN
  ,
  output logic             overwrite_err
`endif
);

  logic       auto_q;
  logic       auto_rise;
  logic [1:0] tgt;
  logic [3:0] tgt_oh;
  logic [3:0] mask;
  state_t     state_q, state_d;
  logic [3:0] filled_d;
  logic       done_d;

  // A rising edge of auto_mode restarts the round-robin at lane A this cycle.
  assign auto_rise = auto_mode & ~auto_q;
  assign tgt       = auto_mode ? (auto_rise ? LANE_A : ptr) : sel;
  assign tgt_oh    = onehot4(tgt);
  assign mask      = filled | tgt_oh;

  demux4_rr_ptr u_rr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (auto_rise),
    .en    (auto_mode & in_valid),
    .ptr   (ptr)
  );

  // NOTE: the lane data registers are reset too, so lanes read zero after
  // any reset, including one that lands mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a <= '0;
      out_b <= '0;
      out_c <= '0;
      out_d <= '0;
    end else if (in_valid) begin
      unique case (tgt)
        LANE_A: out_a <= in_data;
        LANE_B: out_b <= in_data;
        LANE_C: out_c <= in_data;
        LANE_D: out_d <= in_data;
      endcase
    end
  end

  // NOTE: every variable is given a default before the case, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    filled_d = filled;
    done_d   = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          filled_d = tgt_oh;
          state_d  = ST_FILL;
        end
        ST_FILL: begin
          if (mask == 4'b1111) begin
            filled_d = 4'b0000;
            state_d  = ST_IDLE;
            done_d   = 1'b1;
          end else begin
            filled_d = mask;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      filled     <= 4'b0000;
      frame_done <= 1'b0;
      out_valid  <= 4'b0000;
      auto_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      filled     <= filled_d;
      frame_done <= done_d;
      out_valid  <= in_valid ? tgt_oh : 4'b0000;
      auto_q     <= auto_mode;
    end
  end

`ifdef DEMUX4_OVERWRITE_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overwrite_err <= 1'b0;
    end else begin
      overwrite_err <= in_valid & (|(filled & tgt_oh));
    end
  end
`endif

endmodule

// File: tb/tb_demux4_seq.sv
// Self-checking bench for demux4_seq: a behavioural model pushes expected
// outputs to a scoreboard queue as each word is driven; they are popped one clock later.
module tb_demux4_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic [1:0]   sel;
  logic         auto_mode;
  logic [W-1:0] out_a, out_b, out_c, out_d;
  logic [3:0]   out_valid;
  logic [3:0]   filled;
  logic         frame_done;
  logic [1:0]   ptr;
`ifdef DEMUX4_OVERWRITE_ERR_EN
  logic         overwrite_err;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] lane [4];
    logic [3:0]   ov;
    logic [3:0]   filled;
    logic         fd;
    logic [1:0]   ptr;
    logic         ow;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [W-1:0] m_lane [4];
  logic [3:0]   m_filled;
  logic [1:0]   m_ptr;
  logic         m_auto_q;
  int           ow_count;

  demux4_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .sel        (sel),
    .auto_mode  (auto_mode),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_c      (out_c),
    .out_d      (out_d),
    .out_valid  (out_valid),
    .filled     (filled),
    .frame_done (frame_done),
    .ptr        (ptr)
`ifdef DEMUX4_OVERWRITE_ERR_EN
    ,
    .overwrite_err (overwrite_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_lane[i] = '0;
    m_filled = 4'b0000;
    m_ptr    = 2'd0;
    m_auto_q = 1'b0;
  endtask

  // Drive one cycle of stimulus, push the model's expectation, pop and score it.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [1:0] s,
                      input logic a);
    exp_t       e;
    exp_t       got;
    logic       rise;
    logic [1:0] t;
    logic [3:0] msk;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    sel       = s;
    auto_mode = a;
    rise = a & ~m_auto_q;
    t    = a ? (rise ? 2'd0 : m_ptr) : s;
    e.ov = 4'b0000;
    e.fd = 1'b0;
    e.ow = 1'b0;
    if (v) begin
      e.ov      = 4'b0001 << t;
      m_lane[t] = d;
      e.ow      = m_filled[t];
      msk       = m_filled | (4'b0001 << t);
      if (msk == 4'b1111) begin
        e.fd     = 1'b1;
        m_filled = 4'b0000;
      end else begin
        m_filled = msk;
      end
    end
    if (rise) m_ptr = v ? 2'd1 : 2'd0;
    else if (a && v) m_ptr = m_ptr + 2'd1;
    m_auto_q = a;
    for (int i = 0; i < 4; i++) e.lane[i] = m_lane[i];
    e.filled = m_filled;
    e.ptr    = m_ptr;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    checks++;
    if ({out_d, out_c, out_b, out_a} !== {got.lane[3], got.lane[2], got.lane[1], got.lane[0]}) begin
      errors++;
      $display("FAIL sb_lanes: got d..a=%h %h %h %h expected %h %h %h %h", out_d, out_c, out_b,
               out_a, got.lane[3], got.lane[2], got.lane[1], got.lane[0]);
    end
    checks++;
    if (out_valid !== got.ov) begin
      errors++;
      $display("FAIL sb_out_valid: got %b expected %b", out_valid, got.ov);
    end
    checks++;
    if (filled !== got.filled) begin
      errors++;
      $display("FAIL sb_filled: got %b expected %b", filled, got.filled);
    end
    checks++;
    if (frame_done !== got.fd) begin
      errors++;
      $display("FAIL sb_frame_done: got %b expected %b", frame_done, got.fd);
    end
    checks++;
    if (ptr !== got.ptr) begin
      errors++;
      $display("FAIL sb_ptr: got %0d expected %0d", ptr, got.ptr);
    end
`ifdef DEMUX4_OVERWRITE_ERR_EN
    checks++;
    if (overwrite_err !== got.ow) begin
      errors++;
      $display("FAIL sb_overwrite_err: got %b expected %b", overwrite_err, got.ow);
    end
    if (overwrite_err === 1'b1) ow_count++;
`endif
  endtask

  // Assert reset mid-cycle, check outputs cleared before any clock edge, release on a negedge.
  task automatic do_reset(input string tag);
    #2;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    auto_mode = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({out_a, out_b, out_c, out_d, out_valid, filled, frame_done, ptr} !== '0) begin
      errors++;
      $display("FAIL %s: outputs a=%h b=%h c=%h d=%h ov=%b filled=%b fd=%b ptr=%0d expected all zero",
               tag, out_a, out_b, out_c, out_d, out_valid, filled, frame_done, ptr);
    end
`ifdef DEMUX4_OVERWRITE_ERR_EN
    checks++;
    if (overwrite_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_overwrite_err: got %b expected 0", tag, overwrite_err);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    sel       = 2'd0;
    auto_mode = 1'b0;
    @(posedge clk);
    #1;
    do_reset("reset_initial");
  endtask

  task automatic test_explicit();
    step(1'b1, 8'hA5, 2'b10, 1'b0);
    checks++;
    if (out_c !== 8'hA5 || out_valid !== 4'b0100 || filled !== 4'b0100) begin
      errors++;
      $display("FAIL explicit_write: got c=%h ov=%b filled=%b expected a5 0100 0100",
               out_c, out_valid, filled);
    end
    checks++;
    if ({out_a, out_b, out_d} !== '0) begin
      errors++;
      $display("FAIL explicit_others: got a=%h b=%h d=%h expected 0", out_a, out_b, out_d);
    end
    step(1'b0, 8'h00, 2'b10, 1'b0);
    checks++;
    if (out_valid !== 4'b0000 || out_c !== 8'hA5) begin
      errors++;
      $display("FAIL explicit_strobe_once: got ov=%b c=%h expected 0000 a5", out_valid, out_c);
    end
    do_reset("reset_after_explicit");
  endtask

  task automatic test_auto();
    logic [W-1:0] words [4];
    logic [1:0]   ptrs  [4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    ptrs  = '{2'd1, 2'd2, 2'd3, 2'd0};
    step(1'b0, 8'h00, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, words[i], 2'b00, 1'b1);
      checks++;
      if (ptr !== ptrs[i] || frame_done !== (i == 3)) begin
        errors++;
        $display("FAIL auto_word%0d: got ptr=%0d fd=%b expected ptr=%0d fd=%b",
                 i, ptr, frame_done, ptrs[i], (i == 3));
      end
    end
    checks++;
    if ({out_a, out_b, out_c, out_d} !== 32'h11223344 || filled !== 4'b0000) begin
      errors++;
      $display("FAIL auto_frame: got lanes=%h%h%h%h filled=%b expected 11223344 0000",
               out_a, out_b, out_c, out_d, filled);
    end
    step(1'b0, 8'h00, 2'b00, 1'b1);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL auto_done_pulse: got %b expected 0", frame_done);
    end
    do_reset("reset_after_auto");
  endtask

  task automatic test_overwrite();
    ow_count = 0;
    step(1'b1, 8'h01, 2'b01, 1'b0);
    step(1'b1, 8'h02, 2'b01, 1'b0);
    checks++;
    if (out_b !== 8'h02 || filled !== 4'b0010 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL overwrite: got b=%h filled=%b fd=%b expected 02 0010 0",
               out_b, filled, frame_done);
    end
`ifdef DEMUX4_OVERWRITE_ERR_EN
    step(1'b0, 8'h00, 2'b01, 1'b0);
    checks++;
    if (ow_count != 1) begin
      errors++;
      $display("FAIL overwrite_err_count: got %0d expected 1", ow_count);
    end
`endif
    do_reset("reset_after_overwrite");
  endtask

  task automatic test_mixed();
    logic [1:0] sels [5];
    logic [3:0] fl   [5];
    sels = '{2'd0, 2'd3, 2'd3, 2'd1, 2'd2};
    fl   = '{4'b0001, 4'b1001, 4'b1001, 4'b1011, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'h50 + i), sels[i], 1'b0);
      checks++;
      if (filled !== fl[i] || frame_done !== (i == 4)) begin
        errors++;
        $display("FAIL mixed_word%0d: got filled=%b fd=%b expected %b %b",
                 i, filled, frame_done, fl[i], (i == 4));
      end
    end
    do_reset("reset_after_mixed");
  endtask

  task automatic test_reset_mid_frame();
    step(1'b1, 8'hC1, 2'b00, 1'b1);
    step(1'b1, 8'hC2, 2'b00, 1'b1);
    do_reset("reset_mid_frame");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(8'hD0 + i), 2'b00, 1'b1);
      checks++;
      if (frame_done !== (i == 3)) begin
        errors++;
        $display("FAIL post_reset_frame%0d: got fd=%b expected %b", i, frame_done, (i == 3));
      end
    end
    do_reset("reset_after_mid_frame");
  endtask

  task automatic test_back_to_back();
    logic a;
    a = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) a = ~a;
      step(1'($urandom_range(0, 3) != 0), W'($urandom), 2'($urandom), a);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_explicit();
    test_auto();
    test_overwrite();
    test_mixed();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux4_seq.md
Name: demux4_seq

Overview:
- Registered 1-to-4 demultiplexer: routes each accepted input word to one of four held output registers, chosen by an explicit 2-bit select or an internal round-robin pointer.
- Counterpart to the team's 4:1 mux. Sits on the distribution side, splitting a serial word stream back into four lanes a,b,c,d.
- Tracks which lanes have been written in the current frame and flags frame completion.

Parameters:
- WIDTH, 8, bit width of the data word and of each output lane.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present this cycle.
- in_data  input  WIDTH  input word.
- sel  input  2  explicit lane select: 00=a, 01=b, 10=c, 11=d. Ignored in auto mode.
- auto_mode  input  1  1 = use the internal round-robin pointer instead of sel.
- out_a, out_b, out_c, out_d  output  WIDTH  held lane registers.
- out_valid  output  4  one-cycle strobe per lane. Bit0=a … bit3=d.
- filled  output  4  lanes written in the current frame.
- frame_done  output  1  one-cycle pulse when all four lanes have been written.
- ptr  output  2  current round-robin pointer.

Behaviour:
- Reset (async assert, sync release) clears all state:
  - out_a..out_d = 0, out_valid = 0, filled = 0, frame_done = 0, ptr = 0, state = IDLE.
- Target lane: tgt = auto_mode ? ptr : sel, sampled in the same cycle as in_valid.
- Accepting a word, with in_valid=1 at edge N:
  - lane[tgt] <= in_data;
  - out_valid[tgt] = 1 for exactly the cycle after edge N; otherwise 0.
  - Latency is 1 clock.
- Lanes not targeted hold their value. out_valid is one-hot or zero, never multi-hot.
- Pointer:
  - Increments mod 4 (3 -> 0) on each accepted word while auto_mode=1.
  - Holds while auto_mode=0.
  - A rising edge of auto_mode (registered previous value 0, current 1) loads ptr=0 for that cycle. If in_valid is also 1 in that cycle, the word goes to lane a and ptr becomes 1.
- Frame FSM, 2 states:
  - IDLE (filled==0): an accepted word goes to FILL with filled = onehot(tgt).
  - FILL: each accepted word ORs onehot(tgt) into filled.
  - If the resulting mask is 4'b1111: frame_done=1 for one cycle, filled returns to 0, state returns to IDLE.
  - Rewriting an already-filled lane updates the data and strobes out_valid but does not change filled.
- in_valid=0: no state change, except the auto_mode rising-edge ptr reload.
- Reset mid-frame: filled, ptr and lanes are cleared immediately; no frame_done is issued.
- Width: in_data is copied unmodified; no arithmetic on the data.

Optional Feature:
- Macro DEMUX4_OVERWRITE_ERR_EN.
- When defined, adds output port overwrite_err (1 bit, reset 0). It pulses for one cycle after an accepted word whose tgt lane is already set in filled. This is a sticky-free pulse; data is still written.
- When undefined, the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - lane-index localparams LANE_A=2'd0, LANE_B=2'd1, LANE_C=2'd2, LANE_D=2'd3;
  - FSM state encodings ST_IDLE, ST_FILL;
  - a onehot4 function (2-bit index -> 4-bit one-hot).
- One natural sub-module: demux4_rr_ptr, the 2-bit wrapping pointer with enable and synchronous load-zero.
- Lane registers and FSM stay in the top module.

Test Plan:
- Reset: rst_n=0 asserted mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- Explicit mode, WIDTH=8, auto_mode=0: sel=10, in_data=8'hA5, in_valid=1 for one cycle -> next cycle out_c=8'hA5, out_valid=4'b0100, filled=4'b0100; other lanes stay 0.
- Auto mode: auto_mode=1 (rising edge), then four consecutive words 8'h11, 8'h22, 8'h33, 8'h44 with sel=00 throughout:
  - lanes a..d = 11, 22, 33, 44;
  - ptr sequence 1, 2, 3, 0;
  - frame_done=1 exactly the cycle after the 4th word;
  - filled back to 0.
- Overwrite, explicit sel=01: write 8'h01 then 8'h02 -> out_b=8'h02, filled=4'b0010, no frame_done. With DEMUX4_OVERWRITE_ERR_EN defined, overwrite_err pulses once, on the second write.
- Mixed completion: sel 00, 11, 11, 01, 10 -> frame_done only after the 5th word; filled after each word: 0001, 1001, 1001, 1011, then 0000.
- Reset mid-frame: after two auto-mode writes, pulse rst_n=0 -> ptr=0, filled=0, lanes=0. A subsequent full frame completes normally with frame_done after 4 words.
